score_bcd_accum: RTL and testbench

Decimal score accumulator for the Space Invaders datapath. It accepts point awards from game logic as two-digit BCD values and adds them into a DIGITS-digit BCD score, one digit per clock. It commits the result atomically and drives per-digit 4-bit BCD nibbles directly into the seven-segment decoders, one decoder per HEX display. Outputs are always valid BCD (0-9), so the decoders never receive out-of-range codes.

---
 rtl/score_bcd_accum.sv | 190 +++++++++++++++++++
 tb/tb_score_bcd_accum.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_accum.sv
// score_bcd_accum: DIGITS-digit BCD score accumulator.
// Awards arrive as two-digit BCD and are added one digit per cycle into a
// work register. The score register is written only on commit or clear, so
// the displays never see a partial sum.
//
// Optional feature: define SCORE_HISCORE_EN to build the high-score register.
// Without it, show_hi is ignored and digits always shows the score.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   clr        synchronous clear of score and sat (new game)
//   add_valid  award request
//   add_pts    award, [7:4] tens, [3:0] units (BCD; nibbles above 9 clamp to 9)
//   add_ready  award can be accepted
//   done       one-cycle pulse when a committed score is visible
//   sat        sticky: score saturated at all nines
//   show_hi    display select (0 score, 1 high score)
//   digits     displayed value, nibble k is the 10^k digit
module score_bcd_accum #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  add_valid,
  input  logic [7:0]            add_pts,
  output logic                  add_ready,
  output logic                  done,
  output logic                  sat,
  input  logic                  show_hi,
  output logic [4*DIGITS-1:0]   digits
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0][3:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                 state;
  logic [DIGITS-1:0][3:0] score;
  logic [DIGITS-1:0][3:0] work;
  logic [IDX_W-1:0]       idx;
  logic                   carry;
  logic [3:0]             pts_units;
  logic [3:0]             pts_tens;

  logic [3:0]             operand;
  logic [4:0]             sum_raw;
  logic [3:0]             sum_digit;
  logic                   sum_carry;
  logic [DIGITS-1:0][3:0] commit_val;
  logic [DIGITS-1:0][3:0] score_nxt;
  logic [DIGITS-1:0][3:0] digits_nxt;

  // Out-of-range award nibbles are treated as 9 so the sum stays valid BCD.
  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Single-digit BCD add for the digit selected by idx.
  always_comb begin
    operand   = 4'd0;
    sum_digit = 4'd0;
    sum_carry = 1'b0;
    if (idx == IDX_W'(0)) begin
      operand = pts_units;
    end else if (idx == IDX_W'(1)) begin
      operand = pts_tens;
    end
    sum_raw = 5'(work[idx]) + 5'(operand) + 5'(carry);
    if (sum_raw > 5'd9) begin
      sum_digit = 4'(sum_raw - 5'd10);
      sum_carry = 1'b1;
    end else begin
      sum_digit = sum_raw[3:0];
    end
  end

  // Next score: clear wins, otherwise commit the work register (or all nines on overflow).
  always_comb begin
    commit_val = carry ? ALL_NINES : work;
    score_nxt  = score;
    if (clr) begin
      score_nxt = '0;
    end else if (state == COMMIT) begin
      score_nxt = commit_val;
    end
  end

`ifdef SCORE_HISCORE_EN
  logic [DIGITS-1:0][3:0] hiscore;
  logic [DIGITS-1:0][3:0] hiscore_nxt;

  // Digits are packed MSD-first, so an unsigned vector compare is an MSD-first BCD compare.
  always_comb begin
    hiscore_nxt = hiscore;
    if (!clr && (state == COMMIT) && (commit_val > hiscore)) begin
      hiscore_nxt = commit_val;
    end
    digits_nxt = show_hi ? hiscore_nxt : score_nxt;
  end

  // High score survives clr; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hiscore <= '0;
    end else begin
      hiscore <= hiscore_nxt;
    end
  end
`else
  logic unused_show_hi;
  assign unused_show_hi = show_hi;

  always_comb begin
    digits_nxt = score_nxt;
  end
`endif

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      score     <= '0;
      work      <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      pts_units <= 4'd0;
      pts_tens  <= 4'd0;
      sat       <= 1'b0;
      done      <= 1'b0;
      add_ready <= 1'b1;
      digits    <= '0;
    end else begin
      done   <= 1'b0;
      score  <= score_nxt;
      digits <= digits_nxt;
      if (clr) begin
        state     <= IDLE;
        work      <= '0;
        idx       <= '0;
        carry     <= 1'b0;
        sat       <= 1'b0;
        add_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (add_valid && add_ready) begin
              pts_units <= clamp9(add_pts[3:0]);
              pts_tens  <= clamp9(add_pts[7:4]);
              work      <= score;
              idx       <= '0;
              carry     <= 1'b0;
              add_ready <= 1'b0;
              state     <= ADD;
            end
          end
          ADD: begin
            work[idx] <= sum_digit;
            carry     <= sum_carry;
            if (idx == LAST_IDX) begin
              state <= COMMIT;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          COMMIT: begin
            if (carry) begin
              sat <= 1'b1;
            end
            done      <= 1'b1;
            add_ready <= 1'b1;
            state     <= IDLE;
          end
          default: begin
            state     <= IDLE;
            add_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_bcd_accum.sv
// Testbench for score_bcd_accum: decimal-arithmetic reference model checked
// every cycle, directed scenarios with literal expectations, then random awards.
module tb_score_bcd_accum;

  localparam int unsigned DIGITS = 4;
  localparam int MAXV = (10 ** DIGITS) - 1;
`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                clr = 1'b0;
  logic                add_valid = 1'b0;
  logic [7:0]          add_pts = 8'h00;
  logic                show_hi = 1'b0;
  logic                add_ready;
  logic                done;
  logic                sat;
  logic [4*DIGITS-1:0] digits;

  int n_cmp = 0;
  int n_mis = 0;

  score_bcd_accum #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .add_valid (add_valid),
    .add_pts   (add_pts),
    .add_ready (add_ready),
    .done      (done),
    .sat       (sat),
    .show_hi   (show_hi),
    .digits    (digits)
  );

  always #5 clk = ~clk;

  // Reference model: plain decimal integers and a busy countdown.
  int m_score = 0;
  int m_hi    = 0;
  int m_pend  = 0;
  int m_busy  = 0;
  int m_shown = 0;
  bit m_sat   = 1'b0;
  bit m_done  = 1'b0;

  function automatic int clampi(input logic [3:0] n);
    return (n > 4'd9) ? 9 : int'(n);
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < int'(DIGITS); k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_score = 0;
      m_hi    = 0;
      m_pend  = 0;
      m_busy  = 0;
      m_sat   = 1'b0;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (clr) begin
        m_score = 0;
        m_sat   = 1'b0;
        m_busy  = 0;
      end else if (m_busy == 0) begin
        if (add_valid) begin
          m_pend = m_score + 10 * clampi(add_pts[7:4]) + clampi(add_pts[3:0]);
          m_busy = int'(DIGITS) + 1;
        end
      end else begin
        m_busy = m_busy - 1;
        if (m_busy == 0) begin
          if (m_pend > MAXV) begin
            m_score = MAXV;
            m_sat   = 1'b1;
          end else begin
            m_score = m_pend;
          end
          if (HI_EN && (m_score > m_hi)) m_hi = m_score;
          m_done = 1'b1;
        end
      end
    end
    m_shown = (HI_EN && show_hi) ? m_hi : m_score;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Cycle-by-cycle compare against the model, just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    chk("add_ready", 32'(add_ready), 32'(m_busy == 0));
    chk("done",      32'(done),      32'(m_done));
    chk("sat",       32'(sat),       32'(m_sat));
    chk("digits",    32'(digits),    32'(to_bcd(m_shown)));
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic wait_ready();
    int n;
    n = 0;
    while (add_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) timeout_fail("ready_wait");
  endtask

  // Issue one award and wait for its done pulse; lat = edges from accept to commit.
  task automatic award_lat(input logic [7:0] p, output int lat);
    wait_ready();
    add_valid = 1'b1;
    add_pts   = p;
    @(negedge clk);
    add_valid = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 64) timeout_fail("done_wait");
  endtask

  task automatic award(input logic [7:0] p);
    int d;
    award_lat(p, d);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_digits", 32'(digits),    32'h0);
    chk("rst_ready",  32'(add_ready), 32'h1);
    chk("rst_done",   32'(done),      32'h0);
    chk("rst_sat",    32'(sat),       32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Basic adds and commit latency
    award_lat(8'h25, lat);
    chk("lat_25", 32'(lat), 32'(DIGITS + 1));
    award_lat(8'h38, lat);
    chk("lat_38", 32'(lat), 32'(DIGITS + 1));
    chk("sum_0063", 32'(digits), 32'h0063);

    // Carry across two digits, then clamped nibble
    do_clr();
    award(8'h95);
    award(8'h07);
    chk("sum_0102", 32'(digits), 32'h0102);
    award(8'h9F);
    chk("sum_0201", 32'(digits), 32'h0201);

    // Saturation and clear
    do_clr();
    repeat (100) award(8'h99);
    award(8'h90);
    chk("sum_9990", 32'(digits), 32'h9990);
    award(8'h25);
    chk("sat_digits", 32'(digits), 32'h9999);
    chk("sat_flag",   32'(sat),    32'h1);
    award(8'h01);
    chk("sat_keep",   32'(digits), 32'h9999);
    do_clr();
    chk("clr_digits", 32'(digits), 32'h0000);
    chk("clr_sat",    32'(sat),    32'h0);

    // clr two cycles after accept drops the award
    wait_ready();
    add_valid = 1'b1;
    add_pts   = 8'h50;
    @(negedge clk);
    add_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_ready",  32'(add_ready), 32'h1);
    chk("abort_digits", 32'(digits),    32'h0000);
    seen = 0;
    repeat (DIGITS + 3) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'h0);

    // Back-to-back awards with add_valid held
    wait_ready();
    add_valid = 1'b1;
    add_pts   = 8'h11;
    repeat (2 * (DIGITS + 2)) @(negedge clk);
    chk("b2b_done",   32'(done),   32'h1);
    chk("b2b_digits", 32'(digits), 32'h0022);
    add_valid = 1'b0;
    @(negedge clk);

    // Asynchronous reset during ADD, award held through release
    wait_ready();
    add_valid = 1'b1;
    add_pts   = 8'h12;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_digits", 32'(digits),    32'h0);
    chk("arst_ready",  32'(add_ready), 32'h1);
    chk("arst_done",   32'(done),      32'h0);
    chk("arst_sat",    32'(sat),       32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_accept", 32'(add_ready), 32'h0);
    add_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) timeout_fail("arst_done_wait");
    chk("arst_sum", 32'(digits), 32'h0012);

    // High-score display
    do_clr();
    award(8'h99);
    award(8'h21);
    chk("hi_0120", 32'(digits), 32'h0120);
    do_clr();
    award(8'h80);
    show_hi = 1'b1;
    @(negedge clk);
`ifdef SCORE_HISCORE_EN
    chk("hi_show", 32'(digits), 32'h0120);
    award(8'h41);
    chk("hi_update", 32'(digits), 32'h0121);
    show_hi = 1'b0;
    @(negedge clk);
    chk("hi_score", 32'(digits), 32'h0121);
`else
    chk("nohi_show", 32'(digits), 32'h0080);
`endif
    show_hi = 1'b0;

    // Random awards, clears and display toggles
    for (int c = 0; c < 3000; c++) begin
      add_valid = ($urandom_range(0, 3) != 0);
      add_pts   = 8'($urandom);
      clr       = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) show_hi = ~show_hi;
      @(negedge clk);
    end
    add_valid = 1'b0;
    clr       = 1'b0;
    repeat (DIGITS + 3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
